// File: rtl/slink_fifo_wr_arbiter_if.sv
// Write-side bundle between the link-layer packet sources, the arbiter and
// the clock-crossing FIFO write port.
// The slave view belongs to the arbiter. The master view belongs to whatever
// drives the requesters and models the FIFO flags.
interface slink_fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 40
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         fifo_winc;
    logic [DATA_SIZE-1:0]         fifo_wdata;
    logic                         fifo_wfull;
    logic                         fifo_almost_full;

    modport master (
        output req_valid, req_last, req_data, fifo_wfull, fifo_almost_full,
        input  req_ready, fifo_winc, fifo_wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_wfull, fifo_almost_full,
        output req_ready, fifo_winc, fifo_wdata
    );
endinterface

// File: rtl/slink_fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter for the slink FIFO write port.
// One requester is locked in from its grant until its last beat is written.
// FIFO full, and optionally almost-full, holds off beats but never arbitration.
module slink_fifo_wr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_SIZE = 40,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   swi_enable,
    input  logic                   swi_use_almost_full,
    slink_fifo_wr_arbiter_if.slave bus,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;
    logic               stall;
    logic               grant;
    logic               done;
    logic [NUM_REQ-1:0] ready_int;
    logic               winc_int;

    assign stall          = bus.fifo_wfull | (swi_use_almost_full & bus.fifo_almost_full);
    assign bus.req_ready  = ready_int;
    assign bus.fifo_winc  = winc_int;
    assign bus.fifo_wdata = bus.req_data[gnt_idx*DATA_SIZE +: DATA_SIZE];

    // Find the first valid requester at or after rr_ptr. The scan runs from the
    // farthest offset down to the nearest one, so the nearest valid requester wins.
    always_comb begin
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (bus.req_valid[cand_idx]) begin
                winner = cand_idx;
            end
        end
    end

    // Next-state and handshake decode. Ready depends only on the state and the
    // stall flags, never on req_valid.
    always_comb begin
        state_next = state;
        ready_int  = '0;
        winc_int   = 1'b0;
        grant      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (swi_enable && (|bus.req_valid)) begin
                    state_next = LOCKED;
                    grant      = 1'b1;
                end
            end
            LOCKED: begin
                ready_int[gnt_idx] = ~stall;
                winc_int           = bus.req_valid[gnt_idx] & ~stall;
                if (winc_int && bus.req_last[gnt_idx]) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register. Reset drops any packet in flight straight back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping. The round-robin pointer wraps explicitly so that
    // NUM_REQ values that are not a power of two still cycle correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
        end else if (grant) begin
            gnt_idx <= winner;
            busy    <= 1'b1;
        end else if (done) begin
            busy <= 1'b0;
            if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slink_fifo_wr_arbiter.sv
// Directed bench for slink_fifo_wr_arbiter.
// A 4-requester instance covers the main function. A 3-requester instance
// covers the non-power-of-two pointer wrap.
module tb_slink_fifo_wr_arbiter;

    logic       clk;
    logic       reset;
    logic       swi_enable;
    logic       swi_use_almost_full;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       swi_enable3;
    logic       swi_use_almost_full3;
    logic [1:0] gnt_idx3;
    logic       busy3;

    int tests_run;
    int tests_failed;

    slink_fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_SIZE(40)) bus4 ();
    slink_fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_SIZE(40)) bus3 ();

    slink_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_SIZE(40)) dut (
        .clk                 (clk),
        .reset               (reset),
        .swi_enable          (swi_enable),
        .swi_use_almost_full (swi_use_almost_full),
        .bus                 (bus4),
        .gnt_idx             (gnt_idx),
        .busy                (busy)
    );

    slink_fifo_wr_arbiter #(.NUM_REQ(3), .DATA_SIZE(40)) dut3 (
        .clk                 (clk),
        .reset               (reset),
        .swi_enable          (swi_enable3),
        .swi_use_almost_full (swi_use_almost_full3),
        .bus                 (bus3),
        .gnt_idx             (gnt_idx3),
        .busy                (busy3)
    );

    // Free-running write clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                                 input logic wfull, input logic afull);
        @(posedge clk);
        #1;
        bus4.req_valid        = valid;
        bus4.req_last         = last;
        bus4.fifo_wfull       = wfull;
        bus4.fifo_almost_full = afull;
    endtask

    task automatic setData(input int idx, input logic [39:0] value);
        bus4.req_data[idx*40 +: 40] = value;
    endtask

    // Directed sequence. Each step lands 1 ns after a rising edge, updates the
    // inputs, then samples 1 ns later.
    initial begin
        tests_run              = 0;
        tests_failed           = 0;
        reset                  = 1'b1;
        swi_enable             = 1'b1;
        swi_use_almost_full    = 1'b0;
        bus4.req_valid         = '0;
        bus4.req_last          = '0;
        bus4.req_data          = '0;
        bus4.fifo_wfull        = 1'b0;
        bus4.fifo_almost_full  = 1'b0;
        swi_enable3            = 1'b1;
        swi_use_almost_full3   = 1'b0;
        bus3.req_valid         = '0;
        bus3.req_last          = '0;
        bus3.req_data          = '0;
        bus3.fifo_wfull        = 1'b0;
        bus3.fifo_almost_full  = 1'b0;

        #2;
        checkOutput("reset_busy",   64'(busy),           64'h0);
        checkOutput("reset_gnt",    64'(gnt_idx),        64'h0);
        checkOutput("reset_ready",  64'(bus4.req_ready), 64'h0);
        checkOutput("reset_winc",   64'(bus4.fifo_winc), 64'h0);
        checkOutput("reset_rr_ptr", 64'(dut.rr_ptr),     64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single requester, 3-beat packet on requester 1.
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        setData(1, 40'h11);
        #1;
        checkOutput("t1_idle_busy",  64'(busy),           64'h0);
        checkOutput("t1_idle_ready", 64'(bus4.req_ready), 64'h0);
        checkOutput("t1_idle_winc",  64'(bus4.fifo_winc), 64'h0);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t1_gnt",    64'(gnt_idx),         64'h1);
        checkOutput("t1_busy",   64'(busy),            64'h1);
        checkOutput("t1_ready",  64'(bus4.req_ready),  64'h2);
        checkOutput("t1_winc0",  64'(bus4.fifo_winc),  64'h1);
        checkOutput("t1_data0",  64'(bus4.fifo_wdata), 64'h11);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        setData(1, 40'h22);
        #1;
        checkOutput("t1_winc1",  64'(bus4.fifo_winc),  64'h1);
        checkOutput("t1_data1",  64'(bus4.fifo_wdata), 64'h22);
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
        setData(1, 40'h33);
        #1;
        checkOutput("t1_winc2",  64'(bus4.fifo_winc),  64'h1);
        checkOutput("t1_data2",  64'(bus4.fifo_wdata), 64'h33);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t1_end_busy", 64'(busy),           64'h0);
        checkOutput("t1_end_winc", 64'(bus4.fifo_winc), 64'h0);
        checkOutput("t1_end_gnt",  64'(gnt_idx),        64'h1);
        checkOutput("t1_end_rr",   64'(dut.rr_ptr),     64'h2);

        // Round-robin fairness from a fresh reset, all requesters streaming.
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setData(i, 40'hA0 + 40'(i));
        end
        for (int p = 0; p < 5; p++) begin
            automatic int g = p % 4;
            applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("t2_idle_busy_%0d", p),  64'(busy),           64'h0);
            checkOutput($sformatf("t2_idle_ready_%0d", p), 64'(bus4.req_ready), 64'h0);
            applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("t2_gnt_%0d", p),    64'(gnt_idx),         64'(g));
            checkOutput($sformatf("t2_ready_%0d", p),  64'(bus4.req_ready),  64'(4'b0001 << g));
            checkOutput($sformatf("t2_data_%0d", p),   64'(bus4.fifo_wdata), 64'h0A0 + 64'(g));
            applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("t2_ready2_%0d", p), 64'(bus4.req_ready),  64'(4'b0001 << g));
            checkOutput($sformatf("t2_winc2_%0d", p),  64'(bus4.fifo_winc),  64'h1);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t2_end_busy", 64'(busy),       64'h0);
        checkOutput("t2_end_rr",   64'(dut.rr_ptr), 64'h1);

        // FIFO full for 4 cycles in the middle of a 3-beat packet.
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        setData(1, 40'h51);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t3_gnt",   64'(gnt_idx),         64'h1);
        checkOutput("t3_winc0", 64'(bus4.fifo_winc),  64'h1);
        checkOutput("t3_data0", 64'(bus4.fifo_wdata), 64'h51);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
            setData(1, 40'h52);
            #1;
            checkOutput($sformatf("t3_full_winc_%0d", c),  64'(bus4.fifo_winc), 64'h0);
            checkOutput($sformatf("t3_full_ready_%0d", c), 64'(bus4.req_ready), 64'h0);
        end
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t3_resume_winc",  64'(bus4.fifo_winc),  64'h1);
        checkOutput("t3_resume_ready", 64'(bus4.req_ready),  64'h2);
        checkOutput("t3_resume_data",  64'(bus4.fifo_wdata), 64'h52);
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
        setData(1, 40'h53);
        #1;
        checkOutput("t3_winc2", 64'(bus4.fifo_winc),  64'h1);
        checkOutput("t3_data2", 64'(bus4.fifo_wdata), 64'h53);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t3_end_busy", 64'(busy),       64'h0);
        checkOutput("t3_end_rr",   64'(dut.rr_ptr), 64'h2);

        // Almost-full only stalls when selected.
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
        setData(2, 40'h61);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("t4_gnt",       64'(gnt_idx),         64'h2);
        checkOutput("t4_nosel_winc", 64'(bus4.fifo_winc), 64'h1);
        checkOutput("t4_data0",     64'(bus4.fifo_wdata), 64'h61);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
        swi_use_almost_full = 1'b1;
        setData(2, 40'h62);
        #1;
        checkOutput("t4_sel_winc0",  64'(bus4.fifo_winc), 64'h0);
        checkOutput("t4_sel_ready0", 64'(bus4.req_ready), 64'h0);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("t4_sel_winc1",  64'(bus4.fifo_winc), 64'h0);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        #1;
        checkOutput("t4_release_winc", 64'(bus4.fifo_winc),  64'h1);
        checkOutput("t4_release_data", 64'(bus4.fifo_wdata), 64'h62);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        swi_use_almost_full = 1'b0;
        #1;
        checkOutput("t4_end_busy", 64'(busy),       64'h0);
        checkOutput("t4_end_rr",   64'(dut.rr_ptr), 64'h3);

        // Grantee 0 bubbles while requester 3 waits, and enable drops mid-packet.
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
        setData(0, 40'h71);
        setData(3, 40'h7F);
        applyStimulus(4'b1001, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t5_gnt",   64'(gnt_idx),         64'h0);
        checkOutput("t5_ready", 64'(bus4.req_ready),  64'h1);
        checkOutput("t5_data0", 64'(bus4.fifo_wdata), 64'h71);
        applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
        swi_enable = 1'b0;
        #1;
        checkOutput("t5_bubble_winc0",  64'(bus4.fifo_winc), 64'h0);
        checkOutput("t5_bubble_ready0", 64'(bus4.req_ready), 64'h1);
        checkOutput("t5_bubble_busy0",  64'(busy),           64'h1);
        applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
        #1;
        checkOutput("t5_bubble_winc1", 64'(bus4.fifo_winc), 64'h0);
        checkOutput("t5_bubble_gnt1",  64'(gnt_idx),        64'h0);
        applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b0);
        setData(0, 40'h72);
        #1;
        checkOutput("t5_last_winc", 64'(bus4.fifo_winc),  64'h1);
        checkOutput("t5_last_data", 64'(bus4.fifo_wdata), 64'h72);
        checkOutput("t5_last_gnt",  64'(gnt_idx),         64'h0);
        applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t5_end_busy", 64'(busy),       64'h0);
        checkOutput("t5_end_rr",   64'(dut.rr_ptr), 64'h1);
        applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t5_disabled_busy0", 64'(busy), 64'h0);
        applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
        swi_enable = 1'b1;
        #1;
        checkOutput("t5_disabled_busy1", 64'(busy),    64'h0);
        checkOutput("t5_disabled_gnt",   64'(gnt_idx), 64'h0);

        // Requester 3 is granted, then reset lands during its second beat.
        applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("t6_gnt",   64'(gnt_idx),         64'h3);
        checkOutput("t6_winc0", 64'(bus4.fifo_winc),  64'h1);
        checkOutput("t6_data0", 64'(bus4.fifo_wdata), 64'h7F);
        applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
        setData(3, 40'h80);
        #1;
        checkOutput("t6_winc1", 64'(bus4.fifo_winc), 64'h1);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_busy",  64'(busy),           64'h0);
        checkOutput("t6_rst_winc",  64'(bus4.fifo_winc), 64'h0);
        checkOutput("t6_rst_ready", 64'(bus4.req_ready), 64'h0);
        checkOutput("t6_rst_gnt",   64'(gnt_idx),        64'h0);
        checkOutput("t6_rst_rr",    64'(dut.rr_ptr),     64'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;

        // NUM_REQ = 3: a single-beat packet on requester 2 wraps the pointer to 0.
        @(posedge clk);
        #1;
        bus3.req_valid        = 3'b100;
        bus3.req_last         = 3'b100;
        bus3.req_data[80 +: 40] = 40'h91;
        @(posedge clk);
        #1;
        checkOutput("t7_gnt",   64'(gnt_idx3),        64'h2);
        checkOutput("t7_winc",  64'(bus3.fifo_winc),  64'h1);
        checkOutput("t7_data",  64'(bus3.fifo_wdata), 64'h91);
        @(posedge clk);
        #1;
        bus3.req_valid = 3'b011;
        bus3.req_last  = 3'b011;
        #1;
        checkOutput("t7_end_busy", 64'(busy3),       64'h0);
        checkOutput("t7_wrap_rr",  64'(dut3.rr_ptr), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("t7_next_gnt", 64'(gnt_idx3), 64'h0);
        bus3.req_valid = 3'b000;
        bus3.req_last  = 3'b000;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/slink_fifo_wr_arbiter.md
# slink_fifo_wr_arbiter

Packet-atomic round-robin arbiter that shares the single write port of an `slink_fifo_top` instance between up to eight requesters in the write-clock domain. Each requester presents a valid/ready/last stream. The arbiter grants one requester, holds that grant until its last beat is accepted, and throttles on the FIFO's `wfull` or, optionally, `almost_full` flag. It sits directly in front of the FIFO write side, between the link-layer packet sources and the clock-crossing FIFO.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..8.
- `DATA_SIZE`, default 40: beat width. Must match the FIFO `DATA_SIZE`.
- `IDX_W`, derived as `$clog2(NUM_REQ)`: width of the grant index. Localparam, not overridable.

Ports:
- `clk` input 1: write-side clock, shared with the FIFO `wclk`.
- `reset` input 1: asynchronous, active-high reset.
- `swi_enable` input 1: allows new grants. Takes effect only at packet boundaries.
- `swi_use_almost_full` input 1: 1 means `fifo_almost_full` also stalls transfers.
- `req_valid` input NUM_REQ: per-requester beat valid.
- `req_last` input NUM_REQ: per-requester end-of-packet marker, qualified by `req_valid`.
- `req_data` input NUM_REQ*DATA_SIZE: requester i occupies bits `[i*DATA_SIZE +: DATA_SIZE]`.
- `req_ready` output NUM_REQ: per-requester beat accept.
- `fifo_winc` output 1: drives the FIFO `winc`.
- `fifo_wdata` output DATA_SIZE: drives the FIFO `wdata`.
- `fifo_wfull` input 1: from the FIFO `wfull`.
- `fifo_almost_full` input 1: from the FIFO `almost_full`.
- `gnt_idx` output IDX_W: index of the current or most recent grantee.
- `busy` output 1: high while the arbiter is in the LOCKED state.

## Operation
States are IDLE and LOCKED. The state, `rr_ptr` (IDX_W bits), `gnt_idx` and `busy` are all registers.

- **stall** = `fifo_wfull | (swi_use_almost_full & fifo_almost_full)`.

- **IDLE**
  - All `req_ready` are 0 and `fifo_winc` is 0. No transfer happens in IDLE.
  - If `swi_enable` is high and any `req_valid` is high, the winner is the first requester with `req_valid` set, searching i = `rr_ptr`, `rr_ptr`+1, … modulo NUM_REQ.
  - Next cycle: state = LOCKED, `gnt_idx` = winner, `busy` = 1.
  - The stall condition does not block arbitration; it only blocks transfers.

- **LOCKED**
  - `req_ready[gnt_idx]` = ~stall. All other `req_ready` are 0.
  - `fifo_winc` = `req_valid[gnt_idx]` & ~stall.
  - `fifo_wdata` = the `req_data` slice of `gnt_idx`, at all times.
  - A beat transfers when `fifo_winc` = 1.
  - If a transfer occurs with `req_last[gnt_idx]` = 1:
    - next state = IDLE, `busy` = 0.
    - `rr_ptr` = (`gnt_idx` + 1) mod NUM_REQ. This wrap is explicit, not a power-of-two truncation; with NUM_REQ = 3, index 2 wraps to 0.
  - If the grantee drops `req_valid` mid-packet, the arbiter stays LOCKED and inserts a bubble. Other requesters are never granted mid-packet.
  - Deasserting `swi_enable` in LOCKED does not abort the packet. No new grant is made once the arbiter is back in IDLE.

- `gnt_idx` holds its value in IDLE. Only a new grant updates it.
- Valid and last asserted together on a single-beat packet are legal: one transfer, then return to IDLE.
- An asserted `req_last` on a non-granted requester is ignored.

## Timing
Reset values:
- state = IDLE, `rr_ptr` = 0, `gnt_idx` = 0, `busy` = 0.
- `req_ready` = 0 and `fifo_winc` = 0, since both decode from the IDLE state.

Combinational paths:
- `req_ready`, `fifo_winc` and `fifo_wdata` are combinational from registered state, `req_valid`, the stall inputs and `req_data`.
- There is no combinational path from `req_valid` to `req_ready`.

Latency and throughput:
- `req_valid` rising in IDLE is granted on the next edge. The first beat can transfer in the cycle after the grant (1-cycle arbitration latency).
- Within a packet, throughput is 1 beat per cycle while not stalled.
- Exactly one IDLE cycle separates consecutive packets.

Stall behaviour:
- `fifo_winc` is never asserted while `fifo_wfull` = 1.
- A stall deasserting allows a transfer in that same cycle.

Reset:
- Reset asserted mid-packet forces IDLE asynchronously. Outputs go to their reset values immediately.
- Partial-packet cleanup is the source's responsibility.

## Test plan
- **Single requester:** reset, then `req_valid[1]` with a 3-beat packet (data 0x11, 0x22, 0x33; last on the third beat). Expect grant one cycle later, `gnt_idx` = 1, three consecutive `fifo_winc` pulses with matching data, IDLE after the third beat, `rr_ptr` = 2.
- **Round-robin fairness:** all four requesters valid continuously with 2-beat packets. Expect grant order 0, 1, 2, 3, 0, with one IDLE cycle between packets and no `req_ready` to non-grantees.
- **Full back-pressure:** `fifo_wfull` = 1 for 4 cycles mid-packet. Expect `fifo_winc` = 0 and `req_ready` = 0 for those cycles, resuming the same cycle `wfull` drops, with no beat lost or duplicated.
- **Almost-full select:** `fifo_almost_full` = 1 with `swi_use_almost_full` = 0 gives no stall; with `swi_use_almost_full` = 1, transfers stop until `fifo_almost_full` = 0.
- **Lock and enable:** the grantee drops `req_valid` for 2 cycles while requester 3 is valid. Expect no grant to 3 until the grantee's last beat. Then clear `swi_enable`: expect the packet to complete and the arbiter to stay IDLE with `busy` = 0.
- **Reset mid-packet, then NUM_REQ = 3:** assert reset during beat 2 and expect immediate IDLE, with `rr_ptr` and `gnt_idx` at 0. Then, with NUM_REQ = 3, grant requester 2 and expect `rr_ptr` to wrap to 0.
